// File: rtl/display_scan_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// display_scan_ctrl_pkg
//   Shared definitions for the multi-digit 7-segment scan controller:
//   default digit count, nibble width, FSM state encoding and a small helper
//   used to size counters safely.
// ----------------------------------------------------------------------------
package display_scan_ctrl_pkg;

    localparam int DISP_NUM_DIGITS = 4;
    localparam int DISP_NIBBLE_W   = 4;

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_SHOW  = 1'b1
    } scan_state_e;

    // $clog2 of the limit, but never narrower than one bit so that a limit of
    // 1 still yields a legal (constant-zero) counter.
    function automatic int cnt_width(input int limit);
        return (limit > 1) ? $clog2(limit) : 1;
    endfunction

endpackage

// File: rtl/display_scan_ctrl_scan_timer.sv
// ----------------------------------------------------------------------------
// display_scan_ctrl_scan_timer
//   Window timing for the scan controller. A down-counter measures the
//   current BLANK or SHOW window; inside SHOW a slice counter divides the
//   dwell into 2**DUTY_BITS equal PWM slices.
// Ports
//   clk              clock
//   rst_n            synchronous active-low reset (counter starts a BLANK window)
//   show_i           current FSM state is SHOW
//   win_end_o        this cycle is the last one of the current window
//   slice_idx_next_o slice index that will be current on the next cycle
// ----------------------------------------------------------------------------
module display_scan_ctrl_scan_timer
    import display_scan_ctrl_pkg::*;
#(
    parameter int DWELL_CYCLES = 10000,
    parameter int BLANK_CYCLES = 16,
    parameter int DUTY_BITS    = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 show_i,
    output logic                 win_end_o,
    output logic [DUTY_BITS-1:0] slice_idx_next_o
);

    localparam int SLICE_CYCLES = DWELL_CYCLES >> DUTY_BITS;
    localparam int CNT_W = cnt_width((DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES);
    localparam int SLC_W = cnt_width(SLICE_CYCLES);

    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [SLC_W-1:0] SLICE_LAST = SLC_W'(SLICE_CYCLES - 1);

    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [SLC_W-1:0]     slc_cnt_q, slc_cnt_d;
    logic [DUTY_BITS-1:0] slc_idx_q, slc_idx_d;
    logic                 win_end;
    logic                 slice_end;

    assign win_end   = (cnt_q == '0);
    assign slice_end = (slc_cnt_q == SLICE_LAST);

    always_comb begin
        cnt_d     = cnt_q;
        slc_cnt_d = slc_cnt_q;
        slc_idx_d = slc_idx_q;
        if (win_end) begin
            // Next window is the opposite kind of the current one.
            cnt_d     = show_i ? BLANK_LAST : DWELL_LAST;
            slc_cnt_d = '0;
            slc_idx_d = '0;
        end else begin
            cnt_d = cnt_q - 1'b1;
            if (show_i) begin
                // DWELL is a whole number of slices, so the last slice ends
                // together with the window and the index never overflows.
                if (slice_end) begin
                    slc_cnt_d = '0;
                    slc_idx_d = slc_idx_q + 1'b1;
                end else begin
                    slc_cnt_d = slc_cnt_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q     <= BLANK_LAST;
            slc_cnt_q <= '0;
            slc_idx_q <= '0;
        end else begin
            cnt_q     <= cnt_d;
            slc_cnt_q <= slc_cnt_d;
            slc_idx_q <= slc_idx_d;
        end
    end

    assign win_end_o        = win_end;
    assign slice_idx_next_o = slc_idx_d;

endmodule

// File: rtl/display_scan_ctrl.sv
// ----------------------------------------------------------------------------
// display_scan_ctrl
//   Time-multiplexed scan controller for a common-segment multi-digit 7-seg
//   display. Each digit gets a BLANK gap followed by a SHOW dwell with PWM
//   brightness. New digit data arrives through a valid/ready port and is
//   committed only at the frame boundary, so a frame never mixes data.
// Ports
//   clk, rst_n    clock, synchronous active-low reset
//   load_valid/ready/data, dp_mask   load port (nibble k = digit k)
//   brightness    on-time = brightness+1 slices, sampled at SHOW entry
//   digit_sel     one-hot digit enable, zero when off
//   nibble        value for the external seg7 decoder
//   dp_out        decimal point of the lit digit
//   blank         1 = segments off
//   frame_tick    one-cycle pulse when the scan wraps to digit 0
// ----------------------------------------------------------------------------
module display_scan_ctrl
    import display_scan_ctrl_pkg::*;
#(
    parameter int NUM_DIGITS   = DISP_NUM_DIGITS,
    parameter int DWELL_CYCLES = 10000,
    parameter int BLANK_CYCLES = 16,
    parameter int DUTY_BITS    = 3
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              load_valid,
    output logic                              load_ready,
    input  logic [DISP_NIBBLE_W*NUM_DIGITS-1:0] load_data,
    input  logic [NUM_DIGITS-1:0]             dp_mask,
    input  logic [DUTY_BITS-1:0]              brightness,
    output logic [NUM_DIGITS-1:0]             digit_sel,
    output logic [DISP_NIBBLE_W-1:0]          nibble,
    output logic                              dp_out,
    output logic                              blank,
    output logic                              frame_tick
);

    localparam int IDX_W  = cnt_width(NUM_DIGITS);
    localparam int DATA_W = DISP_NIBBLE_W * NUM_DIGITS;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

    scan_state_e                state_q, state_d;
    logic [IDX_W-1:0]           idx_q, idx_d;
    logic [DUTY_BITS-1:0]       bright_q, bright_d;
    logic [DATA_W-1:0]          active_q, active_d;
    logic [NUM_DIGITS-1:0]      active_dp_q, active_dp_d;
    logic [DATA_W-1:0]          pend_data_q, pend_data_d;
    logic [NUM_DIGITS-1:0]      pend_dp_q, pend_dp_d;
    logic                       pend_q, pend_d;
    logic [NUM_DIGITS-1:0]      digit_sel_q, digit_sel_d;
    logic [DISP_NIBBLE_W-1:0]   nibble_q, nibble_d;
    logic                       dp_q, dp_d;
    logic                       blank_q, blank_d;
    logic                       frame_tick_q, frame_tick_d;

    logic                       win_end;
    logic [DUTY_BITS-1:0]       slice_idx_next;
    logic                       on_d;

    display_scan_ctrl_scan_timer #(
        .DWELL_CYCLES (DWELL_CYCLES),
        .BLANK_CYCLES (BLANK_CYCLES),
        .DUTY_BITS    (DUTY_BITS)
    ) u_timer (
        .clk              (clk),
        .rst_n            (rst_n),
        .show_i           (state_q == ST_SHOW),
        .win_end_o        (win_end),
        .slice_idx_next_o (slice_idx_next)
    );

    // FSM next state plus registered-output decode. Outputs are computed from
    // next-state values so they change on the same edge as the FSM/slices.
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        bright_d     = bright_q;
        frame_tick_d = 1'b0;
        case (state_q)
            ST_BLANK: begin
                if (win_end) begin
                    state_d  = ST_SHOW;
                    bright_d = brightness;
                end
            end
            ST_SHOW: begin
                if (win_end) begin
                    state_d = ST_BLANK;
                    if (idx_q == IDX_LAST) begin
                        idx_d        = '0;
                        frame_tick_d = 1'b1;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
        endcase

        on_d        = (state_d == ST_SHOW) && (slice_idx_next <= bright_d);
        digit_sel_d = on_d ? (NUM_DIGITS'(1) << idx_d) : '0;
        blank_d     = ~on_d;
        dp_d        = on_d && active_dp_q[idx_d];
        nibble_d    = (state_d == ST_SHOW) ? active_q[int'(idx_d) * DISP_NIBBLE_W +: DISP_NIBBLE_W]
                                           : nibble_q;
    end

    // Load handshake. The commit happens at the end of the frame_tick cycle,
    // which is always inside digit 0's BLANK gap, so the new data is in place
    // before the first SHOW of the new frame.
    always_comb begin
        active_d    = active_q;
        active_dp_d = active_dp_q;
        pend_data_d = pend_data_q;
        pend_dp_d   = pend_dp_q;
        pend_d      = pend_q;
        if (frame_tick_q && pend_q) begin
            active_d    = pend_data_q;
            active_dp_d = pend_dp_q;
            pend_d      = 1'b0;
        end else if (load_valid && !pend_q) begin
            pend_data_d = load_data;
            pend_dp_d   = dp_mask;
            pend_d      = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_BLANK;
            idx_q        <= '0;
            bright_q     <= '0;
            active_q     <= '0;
            active_dp_q  <= '0;
            pend_data_q  <= '0;
            pend_dp_q    <= '0;
            pend_q       <= 1'b0;
            digit_sel_q  <= '0;
            nibble_q     <= '0;
            dp_q         <= 1'b0;
            blank_q      <= 1'b1;
            frame_tick_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            bright_q     <= bright_d;
            active_q     <= active_d;
            active_dp_q  <= active_dp_d;
            pend_data_q  <= pend_data_d;
            pend_dp_q    <= pend_dp_d;
            pend_q       <= pend_d;
            digit_sel_q  <= digit_sel_d;
            nibble_q     <= nibble_d;
            dp_q         <= dp_d;
            blank_q      <= blank_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    assign load_ready = ~pend_q;
    assign digit_sel  = digit_sel_q;
    assign nibble     = nibble_q;
    assign dp_out     = dp_q;
    assign blank      = blank_q;
    assign frame_tick = frame_tick_q;

endmodule
